// File: rtl/addr_seq_pkg.sv
// Shared constants for the address sequencer: parameter defaults and FSM state encoding.
package addr_seq_pkg;
  localparam int ADDR_W_DEF  = 32;
  localparam int NUM_SRC_DEF = 4;
  localparam int BURST_W_DEF = 4;
  localparam int STRIDE_DEF  = 4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;
endpackage

// File: rtl/addr_sequencer_if.sv
// Memory-side beat handshake of the address sequencer.
interface addr_sequencer_if #(parameter int ADDR_W = 32);
  logic [ADDR_W-1:0] out_mem_address;
  logic [ADDR_W-1:0] out_inc_address;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_mem_address, out_inc_address, out_valid, input out_ready);
  modport slave  (input out_mem_address, out_inc_address, out_valid, output out_ready);
endinterface

// File: rtl/addr_src_mux.sv
// Picks one of NUM_SRC packed address buses; indices past the last source clamp to it.
module addr_src_mux #(
  parameter int ADDR_W  = 32,
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC*ADDR_W-1:0]  in_addr,
  input  logic [$clog2(NUM_SRC)-1:0] in_select,
  output logic [ADDR_W-1:0]          sel_addr
);
  // Default is the top source, so any unmatched index lands there.
  always_comb begin
    sel_addr = in_addr[(NUM_SRC-1)*ADDR_W +: ADDR_W];
    for (int k = 0; k < NUM_SRC - 1; k++)
      if (32'(in_select) == k) sel_addr = in_addr[k*ADDR_W +: ADDR_W];
  end
endmodule

// File: rtl/addr_sequencer.sv
// Burst address sequencer: loads a source address, then walks it by STRIDE per accepted beat.
// Optional alignment check enabled by defining ADDR_SEQ_ALIGN_CHECK_EN.
module addr_sequencer
  import addr_seq_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int BURST_W = BURST_W_DEF,
  parameter int STRIDE  = STRIDE_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC*ADDR_W-1:0]  in_addr,
  input  logic [$clog2(NUM_SRC)-1:0] in_select,
  input  logic                       update_address,
  input  logic                       start_burst,
  input  logic [BURST_W-1:0]         burst_len,
  addr_sequencer_if.master           mem,
  output logic                       busy,
  output logic                       done,
  output logic                       misaligned
);
  logic [0:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] sel_addr;
  logic [BURST_W-1:0] cnt;
  logic              done_q;

  addr_src_mux #(.ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC)) u_mux (
    .in_addr  (in_addr),
    .in_select(in_select),
    .sel_addr (sel_addr)
  );

  // Natural truncation gives the modulo-2^ADDR_W wrap.
  assign addr_inc            = addr + ADDR_W'(STRIDE);
  assign mem.out_mem_address = addr;
  assign mem.out_inc_address = addr_inc;
  assign mem.out_valid       = (state == ST_BURST);
  assign busy                = (state == ST_BURST);
  assign done                = done_q;

`ifdef ADDR_SEQ_ALIGN_CHECK_EN
  logic mis_q;
  logic sel_mis;
  assign sel_mis    = |(sel_addr & ADDR_W'(STRIDE - 1));
  assign misaligned = mis_q;
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      addr   <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
`ifdef ADDR_SEQ_ALIGN_CHECK_EN
      mis_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_burst && burst_len != '0) begin
            addr <= sel_addr;
`ifdef ADDR_SEQ_ALIGN_CHECK_EN
            mis_q <= sel_mis;
            // A misaligned start still loads the address but never launches.
            if (!sel_mis) begin
              cnt   <= burst_len;
              state <= ST_BURST;
            end
`else
            cnt   <= burst_len;
            state <= ST_BURST;
`endif
          end else if (update_address) begin
            addr <= sel_addr;
`ifdef ADDR_SEQ_ALIGN_CHECK_EN
            mis_q <= sel_mis;
`endif
          end
        end
        default: begin
          if (mem.out_ready) begin
            addr <= addr_inc;
            cnt  <= cnt - BURST_W'(1);
            if (cnt == BURST_W'(1)) begin
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_addr_sequencer.sv
// Scoreboard bench for addr_sequencer: stimulus pushes expected beat addresses, a monitor checks accepted beats.
module tb_addr_sequencer;
  localparam int ADDR_W = 32, NUM_SRC = 4, BURST_W = 4;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_SRC*ADDR_W-1:0] in_addr;
  logic [1:0]                in_select;
  logic                      update_address, start_burst;
  logic [BURST_W-1:0]        burst_len;
  logic                      busy, done, misaligned;

  addr_sequencer_if #(.ADDR_W(ADDR_W)) mem_if();

  addr_sequencer #(.ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .BURST_W(BURST_W), .STRIDE(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_addr       (in_addr),
    .in_select     (in_select),
    .update_address(update_address),
    .start_burst   (start_burst),
    .burst_len     (burst_len),
    .mem           (mem_if),
    .busy          (busy),
    .done          (done),
    .misaligned    (misaligned)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_if.out_valid && mem_if.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", mem_if.out_mem_address, 32'hDEAD_BEEF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("beat_addr", mem_if.out_mem_address, e);
        chk("beat_inc", mem_if.out_inc_address, e + 32'd4);
        chk("beat_busy", {31'd0, busy}, 32'd1);
      end
    end
  end

  initial begin
    reset = 1'b1;
    in_addr = {32'h0000_3000, 32'hFFFF_FFFC, 32'h0000_1000, 32'h0000_2000};
    in_select = 2'd0;
    update_address = 1'b0;
    start_burst = 1'b0;
    burst_len = '0;
    mem_if.out_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_addr", mem_if.out_mem_address, 32'h0);
    chk("rst_inc", mem_if.out_inc_address, 32'h4);
    chk("rst_valid", {31'd0, mem_if.out_valid}, 32'd0);
    chk("rst_busy_done_mis", {29'd0, busy, done, misaligned}, 32'd0);
    tick();
    reset = 1'b0;

    // Plain load from source 1
    in_select = 2'd1; update_address = 1'b1;
    tick();
    update_address = 1'b0;
    @(negedge clk);
    chk("load_addr", mem_if.out_mem_address, 32'h1000);
    chk("load_inc", mem_if.out_inc_address, 32'h1004);
    chk("load_valid", {31'd0, mem_if.out_valid}, 32'd0);

    // Load from the top source
    tick();
    in_select = 2'd3; update_address = 1'b1;
    tick();
    update_address = 1'b0;
    @(negedge clk);
    chk("load_src3", mem_if.out_mem_address, 32'h3000);

    // Burst of 3, update_address also high: start must win
    tick();
    exp_q.push_back(32'h2000); exp_q.push_back(32'h2004); exp_q.push_back(32'h2008);
    in_select = 2'd0; start_burst = 1'b1; update_address = 1'b1; burst_len = 4'd3;
    mem_if.out_ready = 1'b1;
    tick();
    start_burst = 1'b0; update_address = 1'b0;
    wait_done(20);
    chk("b3_end_addr", mem_if.out_mem_address, 32'h200C);
    chk("b3_end_valid_busy", {30'd0, mem_if.out_valid, busy}, 32'd0);
    @(negedge clk);
    chk("b3_done_pulse", {31'd0, done}, 32'd0);

    // Burst of 2 with a 3-cycle stall on beat 0
    tick();
    mem_if.out_ready = 1'b0;
    start_burst = 1'b1; burst_len = 4'd2;
    tick();
    start_burst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_addr", mem_if.out_mem_address, 32'h2000);
      chk("stall_busy_valid", {30'd0, busy, mem_if.out_valid}, 32'd3);
    end
    exp_q.push_back(32'h2000); exp_q.push_back(32'h2004);
    tick();
    mem_if.out_ready = 1'b1;
    wait_done(20);
    chk("stall_end_addr", mem_if.out_mem_address, 32'h2008);

    // Wrap across 2^32
    tick();
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0000_0000);
    in_select = 2'd2; start_burst = 1'b1; burst_len = 4'd2;
    tick();
    start_burst = 1'b0;
    wait_done(20);
    chk("wrap_end_addr", mem_if.out_mem_address, 32'h4);

    // Zero-length start is a no-op
    tick();
    in_select = 2'd0; start_burst = 1'b1; burst_len = 4'd0;
    tick();
    start_burst = 1'b0;
    @(negedge clk);
    chk("zlen_addr", mem_if.out_mem_address, 32'h4);
    chk("zlen_valid_busy_done", {29'd0, mem_if.out_valid, busy, done}, 32'd0);

    // Reset while beat 1 of 4 is on the bus
    tick();
    exp_q.push_back(32'h3000); exp_q.push_back(32'h3004);
    in_select = 2'd3; start_burst = 1'b1; burst_len = 4'd4;
    tick();
    start_burst = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_addr", mem_if.out_mem_address, 32'h0);
    chk("rst_mid_valid_busy_done", {29'd0, mem_if.out_valid, busy, done}, 32'd0);
    @(negedge clk);
    chk("rst_mid_no_done", {31'd0, done}, 32'd0);

    // Misaligned start
    tick();
    in_addr[32 +: 32] = 32'h0000_2002;
    in_select = 2'd1; start_burst = 1'b1; burst_len = 4'd1;
`ifdef ADDR_SEQ_ALIGN_CHECK_EN
    tick();
    start_burst = 1'b0;
    @(negedge clk);
    chk("mis_flag", {31'd0, misaligned}, 32'd1);
    chk("mis_idle", {30'd0, mem_if.out_valid, busy}, 32'd0);
    chk("mis_addr", mem_if.out_mem_address, 32'h2002);
    tick();
    in_select = 2'd0; update_address = 1'b1;
    tick();
    update_address = 1'b0;
    @(negedge clk);
    chk("mis_clear", {31'd0, misaligned}, 32'd0);
`else
    exp_q.push_back(32'h2002);
    tick();
    start_burst = 1'b0;
    @(negedge clk);
    chk("mis_off_flag", {31'd0, misaligned}, 32'd0);
    wait_done(20);
    chk("mis_off_end_addr", mem_if.out_mem_address, 32'h2006);
`endif

    tick(); tick();
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/addr_sequencer.md
ADDR_SEQUENCER -- requirements
Module: addr_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-002 SHALL have parameter NUM_SRC, default 4, number of address source buses (2..8).
REQ-003 SHALL have parameter BURST_W, default 4, width of burst length field.
REQ-004 SHALL have parameter STRIDE, default 4, byte increment per beat (power of two).
REQ-005 SHALL have ports: clk  in  1  single clock, all logic on posedge.
REQ-006 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have: in_addr  in  NUM_SRC*ADDR_W  packed source buses, source k at bits [k*ADDR_W +: ADDR_W].
REQ-008 SHALL have: in_select  in  clog2(NUM_SRC)  source index.
REQ-009 SHALL have: update_address  in  1  single-cycle load request.
REQ-010 SHALL have: start_burst  in  1  burst start request; burst_len  in  BURST_W  beat count.
REQ-011 SHALL have: out_mem_address  out  ADDR_W  current address; out_inc_address  out  ADDR_W  current+STRIDE.
REQ-012 SHALL have: out_valid  out  1; out_ready  in  1  memory-side handshake.
REQ-013 SHALL have: busy  out  1  high in BURST; done  out  1  one-cycle pulse after final beat; misaligned  out  1.

Function
REQ-014 SHALL implement FSM states IDLE and BURST.
REQ-015 SHALL, in IDLE with update_address=1, load selected source into address next cycle; out_valid stays 0.
REQ-016 SHALL, in IDLE with start_burst=1 and burst_len!=0, load selected source, set beat counter=burst_len, enter BURST next cycle.
REQ-017 SHALL treat start_burst with burst_len=0 as no-op (no state, address, or done change).
REQ-018 SHALL give start_burst priority over update_address when both high in IDLE.
REQ-019 SHALL select source NUM_SRC-1 when in_select >= NUM_SRC.
REQ-020 SHALL hold out_valid=1 and busy=1 throughout BURST; out_mem_address stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, per accepted beat (out_valid & out_ready), advance address by STRIDE and decrement counter in the same edge.
REQ-022 SHALL wrap address modulo 2^ADDR_W; no overflow flag.
REQ-023 SHALL, on acceptance of final beat, return to IDLE, drop out_valid, pulse done for exactly one cycle; address then holds last+STRIDE.
REQ-024 SHALL ignore update_address and start_burst while in BURST.
REQ-025 SHALL drive out_inc_address combinationally as out_mem_address+STRIDE, truncated to ADDR_W.

Reset
REQ-026 SHALL on reset=1 at posedge force IDLE, address 0, counter 0, out_valid 0, busy 0, done 0, misaligned 0, including mid-burst (burst aborted, no done).

Configuration
REQ-027 SHALL with ADDR_SEQ_ALIGN_CHECK_EN defined: on load/start with low log2(STRIDE) bits of selected source nonzero, set misaligned=1 (held until next load/start/reset), and reject start_burst (stay IDLE) while still loading the address.
REQ-028 SHALL without ADDR_SEQ_ALIGN_CHECK_EN: tie misaligned to 0, accept any address.

Structure
REQ-029 SHALL place FSM state encoding and default parameter constants in shared package addr_seq_pkg.
REQ-030 SHALL implement source selection as sub-module addr_src_mux (parametrised ADDR_W, NUM_SRC, out-of-range clamp).

Verification
REQ-031 SHALL cover: in_select=1, in_addr[1]=0x1000, update_address pulse -> out_mem_address=0x1000, out_inc_address=0x1004, out_valid=0.
REQ-032 SHALL cover: start from 0x2000, burst_len=3, out_ready=1 -> addresses 0x2000,0x2004,0x2008 on consecutive cycles, then done pulse, address 0x200C.
REQ-033 SHALL cover: burst_len=2, out_ready low 3 cycles on beat 0 -> address held 0x2000, busy=1, no counter change.
REQ-034 SHALL cover: start at 0xFFFFFFFC, burst_len=2 -> beats 0xFFFFFFFC, 0x00000000.
REQ-035 SHALL cover: reset asserted after beat 1 of 4 -> next cycle address 0, out_valid 0, busy 0, no done.
REQ-036 SHALL cover (ADDR_SEQ_ALIGN_CHECK_EN): start from 0x2002 -> misaligned=1, stays IDLE, out_valid=0.
